// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode encodings shared by the universal shift register and its bench
package shift_reg_pkg;
   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   function automatic logic is_shift(input logic [1:0] mode);
      return (mode == MODE_SHR) || (mode == MODE_SHL);
   endfunction
endpackage

// File: rtl/shift_frame_cnt.sv
// shift_frame_cnt: counts shift edges per frame, wraps at WIDTH and emits a one-cycle frame_done
module shift_frame_cnt #(
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic                         shift,
   input  logic                         load,
   output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
   output logic                         frame_done
);
   localparam int CW = $clog2(WIDTH + 1);

   logic last;

   assign last = shift_cnt == CW'(WIDTH - 1);

   // advance on enabled shifts, restart on load, pulse frame_done on the wrapping shift
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= en && shift && last;
         if (en && load)
            shift_cnt <= '0;
         else if (en && shift)
            shift_cnt <= last ? '0 : shift_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift register with hold, shift right/left, parallel load and frame counting
module shift_reg_univ
   import shift_reg_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic [1:0]                   mode,
   input  logic                         sdi_r,
   input  logic                         sdi_l,
   input  logic [WIDTH-1:0]             pdi,
   output logic [WIDTH-1:0]             pdo,
   output logic                         sdo_r,
   output logic                         sdo_l,
   output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
   output logic                         frame_done
);
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_next;

   // next register content selected by mode
   always_comb begin
      q_next = mode == MODE_SHR  ? {sdi_r, q[WIDTH-1:1]} :
               mode == MODE_SHL  ? {q[WIDTH-2:0], sdi_l} :
               mode == MODE_LOAD ? pdi : q;
   end

   // data register, frozen when en is low
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= RESET_VALUE;
      else if (en)
         q <= q_next;
   end

   assign pdo   = q;
   assign sdo_r = q[0];
   assign sdo_l = q[WIDTH-1];

   shift_frame_cnt #(.WIDTH(WIDTH)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .shift      (is_shift(mode)),
      .load       (mode == MODE_LOAD),
      .shift_cnt  (shift_cnt),
      .frame_done (frame_done)
   );
endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: randomized and directed checks of shift_reg_univ against a bit-arithmetic model
module tb_shift_reg_univ;
   import shift_reg_pkg::*;

   localparam int               W  = 8;
   localparam logic [W-1:0]     RV = 8'h5A;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         en = 1'b0;
   logic [1:0]   mode = MODE_HOLD;
   logic         sdi_r = 1'b0;
   logic         sdi_l = 1'b0;
   logic [W-1:0] pdi = '0;
   logic [W-1:0] pdo;
   logic         sdo_r, sdo_l;
   logic [3:0]   shift_cnt;
   logic         frame_done;

   int           n_checks = 0;
   int           n_fail = 0;

   logic [W-1:0] m_q = RV;
   int           m_cnt = 0;
   logic         m_fd = 1'b0;

   shift_reg_univ #(.WIDTH(W), .RESET_VALUE(RV)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .mode       (mode),
      .sdi_r      (sdi_r),
      .sdi_l      (sdi_l),
      .pdi        (pdi),
      .pdo        (pdo),
      .sdo_r      (sdo_r),
      .sdo_l      (sdo_l),
      .shift_cnt  (shift_cnt),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_q = RV;
      m_cnt = 0;
      m_fd = 1'b0;
   endtask

   // drive one cycle of inputs, take the edge, then advance the reference model
   task automatic tick(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                       input logic [W-1:0] d);
      en = e; mode = m; sdi_r = sr; sdi_l = sl; pdi = d;
      @(posedge clk);
      if (reset) model_reset();
      else if (!e) m_fd = 1'b0;
      else begin
         m_fd = 1'b0;
         if (m == MODE_LOAD) begin
            m_q = d;
            m_cnt = 0;
         end else if (m == MODE_SHR || m == MODE_SHL) begin
            m_q = (m == MODE_SHR) ? ((m_q >> 1) | (W'(sr) << (W - 1))) : ((m_q << 1) | W'(sl));
            m_cnt = m_cnt + 1;
            if (m_cnt == W) begin
               m_cnt = 0;
               m_fd = 1'b1;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      n_checks++; if (pdo !== RV) begin n_fail++; $display("FAIL reset_pdo: got %h want %h", pdo, RV); end
      n_checks++; if (shift_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", shift_cnt); end
      n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", frame_done); end
      model_reset();
      tick(1'b1, MODE_LOAD, 1'b1, 1'b1, 8'hFF);
      tick(1'b1, MODE_SHL, 1'b1, 1'b1, 8'hFF);
      n_checks++; if (pdo !== RV || shift_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_ignores_inputs: got %h/%0d want %h/0", pdo, shift_cnt, RV); end
      reset = 1'b0;
   endtask

   task automatic test_load();
      tick(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hA5);
      n_checks++; if (pdo !== 8'hA5) begin n_fail++; $display("FAIL load_pdo: got %h want a5", pdo); end
      n_checks++; if (shift_cnt !== 4'd0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL load_cnt_fd: got %0d/%b want 0/0", shift_cnt, frame_done); end
   endtask

   task automatic test_shr_frame();
      logic [7:0] exp_seq;
      exp_seq = 8'b1010_0101;
      tick(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hA5);
      for (int i = 0; i < 8; i++) begin
         n_checks++; if (sdo_r !== exp_seq[i]) begin n_fail++; $display("FAIL shr_sdo_r[%0d]: got %b want %b", i, sdo_r, exp_seq[i]); end
         tick(1'b1, MODE_SHR, 1'b0, 1'b0, 8'h00);
         n_checks++; if (frame_done !== (i == 7)) begin n_fail++; $display("FAIL shr_fd[%0d]: got %b want %b", i, frame_done, i == 7); end
      end
      n_checks++; if (pdo !== 8'h00) begin n_fail++; $display("FAIL shr_pdo_end: got %h want 00", pdo); end
      tick(1'b1, MODE_HOLD, 1'b0, 1'b0, 8'h00);
      n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL shr_fd_single: got %b want 0", frame_done); end
   endtask

   task automatic test_shl_then_shr();
      tick(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h81);
      for (int i = 0; i < 3; i++) tick(1'b1, MODE_SHL, 1'b0, 1'b1, 8'h00);
      n_checks++; if (pdo !== 8'h0F) begin n_fail++; $display("FAIL shl_pdo: got %h want 0f", pdo); end
      n_checks++; if (shift_cnt !== 4'd3) begin n_fail++; $display("FAIL shl_cnt: got %0d want 3", shift_cnt); end
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, MODE_SHR, 1'b0, 1'b0, 8'h00);
         n_checks++; if (frame_done !== (i == 4)) begin n_fail++; $display("FAIL mixed_fd[%0d]: got %b want %b", i, frame_done, i == 4); end
      end
      n_checks++; if (shift_cnt !== 4'd0) begin n_fail++; $display("FAIL mixed_cnt: got %0d want 0", shift_cnt); end
   endtask

   task automatic test_enable();
      logic [W-1:0] p;
      logic [3:0]   c;
      tick(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h3C);
      for (int i = 0; i < 3; i++) tick(1'b1, MODE_SHR, 1'($urandom), 1'b0, 8'h00);
      p = m_q;
      c = 4'd3;
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
         n_checks++; if (pdo !== p || shift_cnt !== c || frame_done !== 1'b0) begin n_fail++; $display("FAIL en_hold[%0d]: got %h/%0d/%b want %h/%0d/0", i, pdo, shift_cnt, frame_done, p, c); end
      end
      for (int i = 0; i < 5; i++) begin
         tick(1'b1, MODE_SHL, 1'b0, 1'($urandom), 8'h00);
         n_checks++; if (frame_done !== (i == 4)) begin n_fail++; $display("FAIL en_resume_fd[%0d]: got %b want %b", i, frame_done, i == 4); end
      end
   endtask

   task automatic test_async_reset_midframe();
      tick(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hC3);
      for (int i = 0; i < 5; i++) tick(1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00);
      #2 reset = 1'b1;
      #1;
      n_checks++; if (pdo !== RV || shift_cnt !== 4'd0) begin n_fail++; $display("FAIL async_reset: got %h/%0d want %h/0", pdo, shift_cnt, RV); end
      model_reset();
      tick(1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00);
      reset = 1'b0;
      tick(1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00);
      n_checks++; if (shift_cnt !== 4'd1) begin n_fail++; $display("FAIL first_shift_after_reset: got %0d want 1", shift_cnt); end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, MODE_SHR, 1'b0, 1'b0, 8'h00);
         n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL partial_frame_fd[%0d]: got %b want 0", i, frame_done); end
      end
   endtask

   task automatic test_latency();
      tick(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h00);
      for (int i = 1; i <= 10; i++) begin
         tick(1'b1, MODE_SHR, i == 1, 1'b0, 8'h00);
         n_checks++; if (sdo_r !== (i == 8)) begin n_fail++; $display("FAIL latency_r[%0d]: got %b want %b", i, sdo_r, i == 8); end
      end
      tick(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h00);
      for (int i = 1; i <= 9; i++) begin
         tick(1'b1, MODE_SHL, 1'b0, i == 1, 8'h00);
         n_checks++; if (sdo_l !== (i == 8)) begin n_fail++; $display("FAIL latency_l[%0d]: got %b want %b", i, sdo_l, i == 8); end
      end
   endtask

   task automatic test_back_to_back();
      tick(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'($urandom));
      for (int i = 0; i < 3 * W; i++) begin
         tick(1'b1, (i % 3 == 0) ? MODE_SHL : MODE_SHR, 1'($urandom), 1'($urandom), 8'h00);
         n_checks++; if (frame_done !== (i % W == W - 1)) begin n_fail++; $display("FAIL b2b_fd[%0d]: got %b want %b", i, frame_done, i % W == W - 1); end
      end
   endtask

   task automatic test_load_after_wrap();
      tick(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h11);
      for (int i = 0; i < W; i++) tick(1'b1, MODE_SHR, 1'b1, 1'b0, 8'h00);
      en = 1'b1; mode = MODE_LOAD; pdi = 8'h99;
      #1;
      n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL wrap_then_load_fd: got %b want 1", frame_done); end
      tick(1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h99);
      n_checks++; if (frame_done !== 1'b0 || shift_cnt !== 4'd0 || pdo !== 8'h99) begin n_fail++; $display("FAIL load_after_wrap: got %b/%0d/%h want 0/0/99", frame_done, shift_cnt, pdo); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 7) != 0), 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
         n_checks++;
         if (pdo !== m_q || shift_cnt !== 4'(m_cnt) || frame_done !== m_fd || sdo_r !== m_q[0] || sdo_l !== m_q[W-1]) begin
            n_fail++;
            $display("FAIL random[%0d]: got q=%h cnt=%0d fd=%b sr=%b sl=%b want q=%h cnt=%0d fd=%b", i, pdo, shift_cnt, frame_done, sdo_r, sdo_l, m_q, m_cnt, m_fd);
         end
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_load();
      test_shr_frame();
      test_shl_then_shr();
      test_enable();
      test_async_reset_midframe();
      test_latency();
      test_back_to_back();
      test_load_after_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
